perf_counter: RTL
=================

// Module: perf_counter
// PURPOSE
//  Performance counter that consumes the writeback-stage stop/retire signals of the pipelined
//  processor. It measures the total cycles, retired instructions and stall cycles of one
//  program run, from the start pulse until the stop instruction reaches writeback. It holds
//  the results for the HEX display readout.
// PARAMETERS
//  CNT_W     16   width of each counter
//  SATURATE  1    1: counters hold at all-ones and set ovf; 0: counters wrap to 0 and set ovf
// PORTS
//  clock       in   1      single system clock, rising edge
//  resetn      in   1      asynchronous, active-low reset
//  start       in   1      run-start pulse (first fetch / KEY), level-sampled each edge
//  stop        in   1      stop from writeback control; high while a stop opcode is in WB
//  retire      in   1      instruction retired in WB this cycle (ir4_load & non-stop)
//  stall       in   1      pipeline stalled this cycle (hazard unit)
//  clear       in   1      synchronous clear of counters and FSM
//  disp_sel    in   2      readout select: 0 cycles, 1 instrs, 2 stalls, 3 status
//  cycle_cnt   out  CNT_W  cycles counted
//  instr_cnt   out  CNT_W  instructions retired
//  stall_cnt   out  CNT_W  stall cycles
//  disp_val    out  CNT_W  registered mux of the above per disp_sel
//  running     out  1      FSM in RUN
//  done        out  1      FSM in HALTED
//  ovf         out  1      sticky: any counter hit all-ones and attempted to increment
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE; all counters, disp_val, ovf = 0; running=done=0.
//  FSM (registered), priority clear > stop > start:
//   IDLE:    start -> RUN. Counters do not count on this edge (start cycle excluded).
//   RUN:     stop -> HALTED. The stop edge itself is counted in cycle_cnt.
//            start is ignored.
//   HALTED:  holds all counts; start and stop are ignored. Only clear leaves this state.
//   any:     clear -> IDLE with counters and ovf zeroed. This overrides start/stop/increments.
//  Counting applies only on edges where state==RUN before the edge:
//   cycle_cnt +1 every such edge.
//   instr_cnt +1 if retire.
//   stall_cnt +1 if stall.
//   retire and stall in the same cycle: both counted. stop with retire: both counted.
//  Inputs are ignored outside RUN, except start in IDLE and clear anywhere.
//  Saturation: counter at 2^CNT_W-1 with increment pending.
//   SATURATE=1: holds at 2^CNT_W-1. SATURATE=0: wraps to 0.
//   Both modes: ovf <= 1, sticky until clear or reset.
//  disp_val: one-cycle latency from disp_sel/counter change.
//   disp_sel=3 gives {zeros, ovf, done, running}, each field LSB-aligned.
//  running/done are decoded directly from the state register (no extra latency).
//  Reset mid-RUN: immediate IDLE with zeroed outputs. No partial results retained.
// STRUCTURE
//  perf_pkg (shared `include): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2;
//   disp_sel codes SEL_CYC/SEL_INS/SEL_STL/SEL_STAT; default CNT_W.
//  Sub-module sat_counter (params CNT_W, SATURATE):
//   ports clock, resetn, clr, inc, q, ovf_pulse. Instantiated three times.
//  Top level holds the FSM, the ovf sticky flag and the disp_val register.
// TESTING
//  1 Reset then start pulse; 10 RUN cycles with retire on 6 and stall on 3; then stop.
//    -> cycle_cnt=11, instr_cnt=6 (7 if retire with stop), stall_cnt=3, done=1, running=0.
//  2 In HALTED apply start, retire and stall for 5 cycles.
//    -> all counts unchanged, state stays HALTED. Then clear -> IDLE, all counts 0.
//  3 CNT_W=4, SATURATE=1: 20 RUN cycles.
//    -> cycle_cnt holds 15, ovf=1. With SATURATE=0: cycle_cnt=20 mod 16=4, ovf=1.
//  4 Same cycle start+clear in IDLE -> remains IDLE.
//    Same cycle stop+clear in RUN -> IDLE, counts 0.
//  5 Assert resetn low asynchronously mid-RUN (between edges).
//    -> outputs 0 immediately without a clock edge. After release, idle until start.
//  6 disp_sel sweep 0..3 in HALTED.
//    -> disp_val equals each counter, then status 3'b010, each one edge after the select change.

Source files
------------

// File: rtl/perf_counter_pkg.sv
// Shared types and constants for the run-time performance counter.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  localparam logic [1:0] SelCyc  = 2'd0;
  localparam logic [1:0] SelIns  = 2'd1;
  localparam logic [1:0] SelStl  = 2'd2;
  localparam logic [1:0] SelStat = 2'd3;

  localparam int unsigned CntWDefault = 16;

endpackage

// File: rtl/perf_counter_sat_counter.sv
// Event counter with synchronous clear; at all-ones it either holds or wraps,
// and flags the overflowing increment with a single-cycle pulse.
module perf_counter_sat_counter #(
  parameter int unsigned CntW     = 16,
  parameter bit          Saturate = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] q_o,
  output logic            ovf_pulse_o
);

  logic [CntW-1:0] q_d, q_q;
  logic            at_max;

  assign at_max = &q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && !(at_max && Saturate)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o         = q_q;
  assign ovf_pulse_o = inc_i & at_max & ~clr_i;

endmodule

// File: rtl/perf_counter.sv
// Measures cycles, retired instructions and stall cycles of one program run,
// from the start pulse until the stop instruction reaches writeback.
module perf_counter
  import perf_counter_pkg::*;
#(
  parameter int unsigned CntW     = CntWDefault,
  parameter bit          Saturate = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            retire_i,
  input  logic            stall_i,
  input  logic            clear_i,
  input  logic [1:0]      disp_sel_i,
  output logic [CntW-1:0] cycle_cnt_o,
  output logic [CntW-1:0] instr_cnt_o,
  output logic [CntW-1:0] stall_cnt_o,
  output logic [CntW-1:0] disp_val_o,
  output logic            running_o,
  output logic            done_o,
  output logic            ovf_o
);

  state_e          state_d, state_q;
  logic            ovf_d, ovf_q;
  logic [CntW-1:0] disp_d, disp_q;
  logic            in_run;
  logic [2:0]      ovf_pulse;

  assign in_run = (state_q == StRun);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_i) state_d = StRun;
        StRun:   if (stop_i) state_d = StHalt;
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    running_o = (state_q == StRun);
    done_o    = (state_q == StHalt);
  end

  perf_counter_sat_counter #(.CntW(CntW), .Saturate(Saturate)) u_cyc (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clear_i),
    .inc_i       (in_run),
    .q_o         (cycle_cnt_o),
    .ovf_pulse_o (ovf_pulse[0])
  );

  perf_counter_sat_counter #(.CntW(CntW), .Saturate(Saturate)) u_ins (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clear_i),
    .inc_i       (in_run & retire_i),
    .q_o         (instr_cnt_o),
    .ovf_pulse_o (ovf_pulse[1])
  );

  perf_counter_sat_counter #(.CntW(CntW), .Saturate(Saturate)) u_stl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clear_i),
    .inc_i       (in_run & stall_i),
    .q_o         (stall_cnt_o),
    .ovf_pulse_o (ovf_pulse[2])
  );

  // Sticky until clear or reset; clear wins over a same-cycle overflow.
  assign ovf_d = clear_i ? 1'b0 : (ovf_q | (|ovf_pulse));

  always_comb begin
    disp_d = '0;
    unique case (disp_sel_i)
      SelCyc:  disp_d = cycle_cnt_o;
      SelIns:  disp_d = instr_cnt_o;
      SelStl:  disp_d = stall_cnt_o;
      SelStat: disp_d = {{(CntW-3){1'b0}}, ovf_q, done_o, running_o};
      default: disp_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q  <= 1'b0;
      disp_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      disp_q <= disp_d;
    end
  end

  assign ovf_o      = ovf_q;
  assign disp_val_o = disp_q;

endmodule
